// File: rtl/obstacle_generator.sv
// Spawns, scrolls and retires up to NUM_OBS rectangular obstacles on a 640x480 playfield.
// Optional macro OBS_SPEEDUP_EN: scroll speed rises by one after every 8 spawns, saturating at 8.
module obstacle_generator #(
    parameter int          NUM_OBS        = 10,
    parameter int          SCREEN_W       = 640,
    parameter int          UPER_BOUND     = 40,
    parameter int          OBS_WIDTH      = 40,
    parameter int          SPEED          = 2,
    parameter int          SPAWN_INTERVAL = 90,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              gamemode,
    input  logic                    frame_tick,
    output logic [20*NUM_OBS-1:0]   obstacle_x,
    output logic [18*NUM_OBS-1:0]   obstacle_y,
    output logic [NUM_OBS-1:0]      active,
    output logic                    spawn_drop
);
    localparam int         CNT_W       = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [9:0] SPAWN_LEFT  = 10'(SCREEN_W - OBS_WIDTH);
    localparam logic [9:0] SPAWN_RIGHT = 10'(SCREEN_W - 1);
    localparam logic [8:0] MIN_HEIGHT  = 9'd40;

    logic [9:0]         left_q  [NUM_OBS];
    logic [9:0]         left_d  [NUM_OBS];
    logic [9:0]         right_q [NUM_OBS];
    logic [9:0]         right_d [NUM_OBS];
    logic [8:0]         top_q   [NUM_OBS];
    logic [8:0]         top_d   [NUM_OBS];
    logic [8:0]         bot_q   [NUM_OBS];
    logic [8:0]         bot_d   [NUM_OBS];
    logic [NUM_OBS-1:0] active_q, active_d, spawn_sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               drop_q, drop_d;
    logic               spawn_ok;
    logic [9:0]         speed;
    logic [8:0]         spawn_top, spawn_bot;

`ifdef OBS_SPEEDUP_EN
    logic [3:0] speed_q, speed_d;
    logic [2:0] tally_q, tally_d;
    assign speed = {6'd0, speed_q};
`else
    assign speed = 10'(SPEED);
`endif

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // One-hot of the lowest slot that is free before this tick's moves.
        spawn_sel = ~active_q & (active_q + NUM_OBS'(1));
        spawn_top = 9'(UPER_BOUND) + {1'b0, lfsr_q[15:8]};
        spawn_bot = spawn_top + MIN_HEIGHT + {2'b00, lfsr_q[6:0]} - 9'd1;
        left_d    = left_q;
        right_d   = right_q;
        top_d     = top_q;
        bot_d     = bot_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        spawn_ok  = 1'b0;
`ifdef OBS_SPEEDUP_EN
        speed_d   = speed_q;
        tally_d   = tally_q;
`endif
        case (gamemode)
            2'b00: begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    left_d[i]  = '0;
                    right_d[i] = '0;
                    top_d[i]   = '0;
                    bot_d[i]   = '0;
                end
                active_d = '0;
                cnt_d    = '0;
`ifdef OBS_SPEEDUP_EN
                speed_d  = 4'(SPEED);
                tally_d  = '0;
`endif
            end
            2'b01: begin
                if (frame_tick) begin
                    for (int i = 0; i < NUM_OBS; i++) begin
                        if (active_q[i]) begin
                            if (right_q[i] <= speed) begin
                                left_d[i]   = '0;
                                right_d[i]  = '0;
                                top_d[i]    = '0;
                                bot_d[i]    = '0;
                                active_d[i] = 1'b0;
                            end else begin
                                right_d[i] = right_q[i] - speed;
                                left_d[i]  = (left_q[i] >= speed) ? left_q[i] - speed : '0;
                            end
                        end
                    end
                    if (cnt_q == CNT_W'(SPAWN_INTERVAL - 1)) begin
                        cnt_d = '0;
                        if (&active_q) drop_d   = 1'b1;
                        else           spawn_ok = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    for (int i = 0; i < NUM_OBS; i++) begin
                        if (spawn_ok && spawn_sel[i]) begin
                            left_d[i]   = SPAWN_LEFT;
                            right_d[i]  = SPAWN_RIGHT;
                            top_d[i]    = spawn_top;
                            bot_d[i]    = spawn_bot;
                            active_d[i] = 1'b1;
                        end
                    end
`ifdef OBS_SPEEDUP_EN
                    if (spawn_ok) begin
                        tally_d = tally_q + 3'd1;
                        if (tally_q == 3'd7 && speed_q < 4'd8) speed_d = speed_q + 4'd1;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                left_q[i]  <= '0;
                right_q[i] <= '0;
                top_q[i]   <= '0;
                bot_q[i]   <= '0;
            end
            active_q <= '0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            drop_q   <= 1'b0;
`ifdef OBS_SPEEDUP_EN
            speed_q  <= 4'(SPEED);
            tally_q  <= '0;
`endif
        end else begin
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bot_q    <= bot_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            drop_q   <= drop_d;
`ifdef OBS_SPEEDUP_EN
            speed_q  <= speed_d;
            tally_q  <= tally_d;
`endif
        end
    end

    for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_pack
        assign obstacle_x[20*gi +: 20] = {left_q[gi], right_q[gi]};
        assign obstacle_y[18*gi +: 18] = {top_q[gi], bot_q[gi]};
    end

    assign active     = active_q;
    assign spawn_drop = drop_q;

endmodule

// File: doc/obstacle_generator.md
# obstacle_generator

Produces the packed obstacle coordinate buses that the game logic and renderer consume. It spawns up to ten rectangular obstacles at the right edge of the 640×480 playfield, scrolls them left once per frame tick, and retires them at the left edge. Sequencing follows the shared 2-bit gamemode: clear in initial, run in in-game, freeze in paused/ended. Placement comes from an internal 16-bit LFSR, so a given reset yields a reproducible sequence.

## Interface
- NUM_OBS, 10, obstacle slots; bus widths scale with it.
- SCREEN_W, 640, playfield width in pixels.
- UPER_BOUND, 40, top of playable area (y).
- OBS_WIDTH, 40, obstacle width in pixels.
- SPEED, 2, pixels moved per frame tick (base speed).
- SPAWN_INTERVAL, 90, frame ticks between spawn attempts.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gamemode  in  2  00=initial, 01=in-game, 10=paused, 11=ended.
- frame_tick  in  1  one-cycle frame strobe; each high cycle is one tick.
- obstacle_x  out  20*NUM_OBS  slot i at [20i+19:20i]: [19:10]=left x, [9:0]=right x.
- obstacle_y  out  18*NUM_OBS  slot i at [18i+17:18i]: [17:9]=top y, [8:0]=bottom y.
- active  out  NUM_OBS  bit i = slot i holds a live obstacle.
- spawn_drop  out  1  one-cycle pulse: spawn attempt found no free slot.

## Operation
- Inactive slot: x field, y field and active bit all zero.
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left every clock in every gamemode. The new bit enters bit 0.
- gamemode 00: synchronous clear of all slots, active, spawn counter, and speedup state. LFSR keeps running.
- gamemode 10/11: every output and internal state holds, except the LFSR. frame_tick is ignored.
- gamemode 01, on each frame_tick:
  - Move, per active slot: if right ≤ SPEED, the slot is freed (all zero). Otherwise right −= SPEED, and left = (left ≥ SPEED) ? left−SPEED : 0.
  - Spawn counter: if counter == SPAWN_INTERVAL−1, the counter goes to 0 and a spawn is attempted. Otherwise the counter increments.
  - Spawn target: the lowest-index slot that was inactive before this tick. A slot freed in the same tick is not reused until a later tick.
  - Spawned values, using L = LFSR value current on the tick cycle:
    - left = SCREEN_W−OBS_WIDTH (600) and right = SCREEN_W−1 (639).
    - top = UPER_BOUND + L[15:8] (40..295).
    - bottom = top + 40 + L[6:0] − 1 (max 461, always < 480).
    - active bit set.
  - No free slot: spawn_drop pulses for one cycle, no slot changes, and the counter still returns to 0.
- Arithmetic: x fields 10 bits unsigned, y fields 9 bits unsigned. Computations use 10 bits; no wrap can occur within the stated ranges.

## Timing
- Reset (async assert, sync release):
  - obstacle_x = 0, obstacle_y = 0, active = 0, spawn_drop = 0.
  - Counter = 0, LFSR = LFSR_SEED.
- All outputs are registered. A frame_tick sampled at edge N is reflected on the outputs after edge N; latency is 1 cycle.
- gamemode changes take effect at the same edge they are sampled. A tick coinciding with a switch to 10 is ignored.
- spawn_drop is high only during the cycle after the tick that caused it.
- rst mid-frame aborts everything immediately. No partial slot update survives.

## Configuration
- OBS_SPEEDUP_EN defined:
  - Speed register starts at SPEED and increments by 1 after every 8 successful spawns, saturating at 8.
  - The move step uses the speed register in place of SPEED, including the free test.
  - The speed register is cleared back to SPEED in gamemode 00 and on reset.
- OBS_SPEEDUP_EN undefined: speed is the constant SPEED. No speed register or spawn tally is built.

## Test plan
- Reset, then mode 01 with 89 ticks: outputs stay all zero. Tick 90: slot 0 becomes active, x = {600,639}, top = 40+L[15:8], bottom = top+39+L[6:0], where L is the reference-model LFSR.
- Spawn, then one more tick: slot 0 x = {598,637}. Continue until right ≤ 2: slot 0 goes to zero and its active bit clears on that tick.
- Mode 10 for 50 ticks mid-game: obstacle_x, obstacle_y and active are unchanged. Return to 01: motion resumes from the held positions.
- SPAWN_INTERVAL=1 with all 10 slots live and none retiring: next tick gives spawn_drop = 1 for exactly one cycle and active stays 10'h3FF.
- Mode 00 asserted with slots live: all outputs are zero the next cycle. Assert rst mid-run: outputs are zero asynchronously and LFSR = 16'hACE1 after release.
- With OBS_SPEEDUP_EN: after 8 spawns, the per-tick x decrement becomes 3. Without the macro, the same stimulus keeps the decrement at 2.
